// File: rtl/dmem_arbiter_if.sv
// Bus interfaces for the data-memory arbiter: one requester-side interface
// (used once for the core, once for the debug/loader) and the RAM-side interface.

interface dmem_req_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wmask;
    logic [DW-1:0] rdata;
    logic          done;

    modport master (output req, we, addr, wdata, wmask, input rdata, done);
    modport slave  (input req, we, addr, wdata, wmask, output rdata, done);
endinterface

interface dmem_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wmask;
    logic [DW-1:0] rdata;

    modport master (output en, we, addr, wdata, wmask, input rdata);
    modport slave  (input en, we, addr, wdata, wmask, output rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core and a debug/loader master.
// Build option DMEM_ARB_DBG_PRIORITY_EN: debug gets fixed priority instead of round-robin.

module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    dmem_req_if.slave  core,
    dmem_req_if.slave  dbg,
    dmem_mem_if.master mem,
    output logic       core_stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT
    } state_t;

    // WAIT runs MEM_LAT cycles, so the counter starts one below the latency.
    localparam logic [3:0] LAT_M1 = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          win_dbg_q;
    logic          m_en_q;
    logic          m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic [3:0]    m_wmask_q;
    logic          c_done_q;
    logic          d_done_q;
    logic [DW-1:0] c_rdata_q;
    logic [DW-1:0] d_rdata_q;

    logic          c_elig;
    logic          d_elig;
    logic          pick_dbg;
    logic [DW-1:0] cap_data;

    // A request whose done is high this cycle is already complete; do not re-grant it.
    assign c_elig = core.req & ~c_done_q;
    assign d_elig = dbg.req & ~d_done_q;

`ifdef DMEM_ARB_DBG_PRIORITY_EN
    assign pick_dbg = d_elig;
`else
    logic last_dbg_q;
    assign pick_dbg = d_elig & (~c_elig | ~last_dbg_q);
`endif

    assign cap_data = m_we_q ? '0 : mem.rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            win_dbg_q <= 1'b0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wmask_q <= '0;
            c_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
`ifndef DMEM_ARB_DBG_PRIORITY_EN
            last_dbg_q <= 1'b1;
`endif
        end else begin
            m_en_q   <= 1'b0;
            c_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (c_elig | d_elig) begin
                        win_dbg_q <= pick_dbg;
                        m_en_q    <= 1'b1;
                        m_we_q    <= pick_dbg ? dbg.we    : core.we;
                        m_addr_q  <= pick_dbg ? dbg.addr  : core.addr;
                        m_wdata_q <= pick_dbg ? dbg.wdata : core.wdata;
                        m_wmask_q <= pick_dbg ? dbg.wmask : core.wmask;
`ifndef DMEM_ARB_DBG_PRIORITY_EN
                        last_dbg_q <= pick_dbg;
`endif
                        state_q   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (MEM_LAT == 0) begin
                        // Combinational RAM: data is already valid while m_en is high.
                        if (win_dbg_q) begin
                            d_rdata_q <= cap_data;
                            d_done_q  <= 1'b1;
                        end else begin
                            c_rdata_q <= cap_data;
                            c_done_q  <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= LAT_M1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        if (win_dbg_q) begin
                            d_rdata_q <= cap_data;
                            d_done_q  <= 1'b1;
                        end else begin
                            c_rdata_q <= cap_data;
                            c_done_q  <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem.en    = m_en_q;
    assign mem.we    = m_we_q;
    assign mem.addr  = m_addr_q;
    assign mem.wdata = m_wdata_q;
    assign mem.wmask = m_wmask_q;

    assign core.rdata = c_rdata_q;
    assign core.done  = c_done_q;
    assign dbg.rdata  = d_rdata_q;
    assign dbg.done   = d_done_q;

    assign core_stall = core.req & ~c_done_q;

endmodule
